// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_pkg
// Description : Opcode and error-cause encodings shared by the program stack,
//               its bus interface and the decoder side.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package stack_pkg;

  localparam int OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] OP_NOP     = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_PUSH    = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_POP     = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_REPLACE = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_DUP     = 3'd4;
  localparam logic [OP_WIDTH-1:0] OP_SWAP    = 3'd5;
  localparam logic [OP_WIDTH-1:0] OP_CLEAR   = 3'd6;
  localparam logic [OP_WIDTH-1:0] OP_ILLEGAL = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_ILL  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/param_program_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : param_program_stack_if
// Description : Decoder <-> program-stack bus. The master (decoder) issues one
//               opcode per cycle; the slave (stack) returns TOS/NOS and status.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface param_program_stack_if
  import stack_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 64
) ();

  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    data_in;
  logic [OP_WIDTH-1:0] op;
  logic                err_clear;
  logic [WIDTH-1:0]    stack_top;
  logic [WIDTH-1:0]    stack_next;
  logic [DW-1:0]       depth;
  logic                empty;
  logic                full;
  logic                err_flag;
  logic [1:0]          err_code;

  modport master (
    output data_in, op, err_clear,
    input  stack_top, stack_next, depth, empty, full, err_flag, err_code
  );

  modport slave (
    input  data_in, op, err_clear,
    output stack_top, stack_next, depth, empty, full, err_flag, err_code
  );

endinterface
`default_nettype wire

// File: rtl/stack_spill_ram.sv
`default_nettype none
// ============================================================================
// Module      : stack_spill_ram
// Description : Backing store for stack entries 3..DEPTH. One synchronous
//               write port (spill of old NOS) and one asynchronous read port
//               (refill of NOS on POP).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module stack_spill_ram #(
  parameter int WIDTH   = 18,
  parameter int ENTRIES = 62,
  parameter int AW      = 6
) (
  input  wire logic             clock,
  input  wire logic             wr_en,
  input  wire logic [AW-1:0]    wr_addr,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic [AW-1:0]    rd_addr,
  output logic      [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [ENTRIES];

  // Single write port; contents need no reset since depth gates every read.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/param_program_stack.sv
`default_nettype none
// ============================================================================
// Module      : param_program_stack
// Description : Parametrised program stack. TOS and NOS live in registers,
//               deeper entries spill into stack_spill_ram. Supports NOP, PUSH,
//               POP, REPLACE, DUP, SWAP and CLEAR with overflow/underflow/
//               illegal-op detection and a sticky first-cause error latch.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module param_program_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 64
) (
  input wire logic             clock,
  input wire logic             reset,
  param_program_stack_if.slave bus
);

  localparam int DW      = $clog2(DEPTH + 1);
  localparam int ENTRIES = DEPTH - 2;
  localparam int AW      = $clog2(ENTRIES);

  logic [WIDTH-1:0] top_q,  top_d;
  logic [WIDTH-1:0] next_q, next_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_flag_q, err_flag_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             err_hit;
  logic [1:0]       err_cause;
  logic             spill_en;
  logic [AW-1:0]    spill_addr;
  logic [AW-1:0]    refill_addr;
  logic [WIDTH-1:0] refill_data;

  logic is_empty;
  logic is_full;
  logic has_two;
  logic has_three;

  assign is_empty  = (depth_q == '0);
  assign is_full   = (depth_q == DW'(DEPTH));
  assign has_two   = (depth_q >= DW'(2));
  assign has_three = (depth_q >= DW'(3));

  // Old NOS spills to slot depth-2; the third entry is read back from depth-3.
  assign spill_addr  = AW'(depth_q - DW'(2));
  assign refill_addr = AW'(depth_q - DW'(3));

  stack_spill_ram #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES),
    .AW      (AW)
  ) u_spill (
    .clock   (clock),
    .wr_en   (spill_en & ~reset),
    .wr_addr (spill_addr),
    .wr_data (next_q),
    .rd_addr (refill_addr),
    .rd_data (refill_data)
  );

  // Opcode decode: legal ops update TOS/NOS/depth, violations only raise a cause.
  always_comb begin
    top_d     = top_q;
    next_d    = next_q;
    depth_d   = depth_q;
    err_hit   = 1'b0;
    err_cause = ERR_NONE;
    spill_en  = 1'b0;
    case (bus.op)
      OP_PUSH: begin
        if (is_full) begin
          err_hit   = 1'b1;
          err_cause = ERR_OVF;
        end else begin
          spill_en = has_two;
          top_d    = bus.data_in;
          next_d   = top_q;
          depth_d  = depth_q + DW'(1);
        end
      end
      OP_POP: begin
        if (is_empty) begin
          err_hit   = 1'b1;
          err_cause = ERR_UNF;
        end else begin
          top_d   = next_q;
          next_d  = has_three ? refill_data : '0;
          depth_d = depth_q - DW'(1);
        end
      end
      OP_REPLACE: begin
        if (is_empty) begin
          err_hit   = 1'b1;
          err_cause = ERR_UNF;
        end else begin
          top_d = bus.data_in;
        end
      end
      OP_DUP: begin
        // An empty stack has nothing to copy, so underflow outranks overflow.
        if (is_empty) begin
          err_hit   = 1'b1;
          err_cause = ERR_UNF;
        end else if (is_full) begin
          err_hit   = 1'b1;
          err_cause = ERR_OVF;
        end else begin
          spill_en = has_two;
          next_d   = top_q;
          depth_d  = depth_q + DW'(1);
        end
      end
      OP_SWAP: begin
        if (!has_two) begin
          err_hit   = 1'b1;
          err_cause = ERR_UNF;
        end else begin
          top_d  = next_q;
          next_d = top_q;
        end
      end
      OP_CLEAR: begin
        top_d   = '0;
        next_d  = '0;
        depth_d = '0;
      end
      OP_ILLEGAL: begin
        err_hit   = 1'b1;
        err_cause = ERR_ILL;
      end
      default: begin
      end
    endcase
  end

  // Error latch: first cause is held; a clear coinciding with a new error loses.
  always_comb begin
    err_flag_d = err_flag_q;
    err_code_d = err_code_q;
    if (err_hit) begin
      err_flag_d = 1'b1;
      if (!err_flag_q || bus.err_clear) begin
        err_code_d = err_cause;
      end
    end else if (bus.err_clear) begin
      err_flag_d = 1'b0;
      err_code_d = ERR_NONE;
    end
  end

  // State registers; reset discards the stack and the op of the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      top_q      <= '0;
      next_q     <= '0;
      depth_q    <= '0;
      err_flag_q <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      top_q      <= top_d;
      next_q     <= next_d;
      depth_q    <= depth_d;
      err_flag_q <= err_flag_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.stack_top  = top_q;
  assign bus.stack_next = next_q;
  assign bus.depth      = depth_q;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.err_flag   = err_flag_q;
  assign bus.err_code   = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_param_program_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_program_stack
// Description : Drives a DEPTH=4 and a DEPTH=64 stack with identical stimulus
//               and compares both against an array-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_program_stack;
  import stack_pkg::*;

  localparam int W = 18;

  logic clock = 1'b0;
  logic reset = 1'b0;

  param_program_stack_if #(.WIDTH(W), .DEPTH(4))  if4  ();
  param_program_stack_if #(.WIDTH(W), .DEPTH(64)) if64 ();

  param_program_stack #(.WIDTH(W), .DEPTH(4))  u4  (.clock(clock), .reset(reset), .bus(if4.slave));
  param_program_stack #(.WIDTH(W), .DEPTH(64)) u64 (.clock(clock), .reset(reset), .bus(if64.slave));

  // 100 MHz clock
  always #5 clock = ~clock;

  // Observed outputs gathered by index: 0 = DEPTH 4, 1 = DEPTH 64.
  logic [W-1:0] obs_top   [2];
  logic [W-1:0] obs_next  [2];
  logic [31:0]  obs_depth [2];
  logic         obs_empty [2];
  logic         obs_full  [2];
  logic         obs_eflag [2];
  logic [1:0]   obs_ecode [2];

  assign obs_top[0]   = if4.stack_top;
  assign obs_top[1]   = if64.stack_top;
  assign obs_next[0]  = if4.stack_next;
  assign obs_next[1]  = if64.stack_next;
  assign obs_depth[0] = 32'(if4.depth);
  assign obs_depth[1] = 32'(if64.depth);
  assign obs_empty[0] = if4.empty;
  assign obs_empty[1] = if64.empty;
  assign obs_full[0]  = if4.full;
  assign obs_full[1]  = if64.full;
  assign obs_eflag[0] = if4.err_flag;
  assign obs_eflag[1] = if64.err_flag;
  assign obs_ecode[0] = if4.err_code;
  assign obs_ecode[1] = if64.err_code;

  // Behavioural model: entries [0..n-1], entry n-1 is the top.
  logic [W-1:0] ms  [2][64];
  int           mn  [2];
  int           mcap[2];
  logic         mef [2];
  logic [1:0]   mec [2];

  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] exp_top(input int k);
    return (mn[k] >= 1) ? ms[k][mn[k]-1] : '0;
  endfunction

  function automatic logic [W-1:0] exp_next(input int k);
    return (mn[k] >= 2) ? ms[k][mn[k]-2] : '0;
  endfunction

  task automatic model_step(input int k, input logic [2:0] o, input logic [W-1:0] d,
                            input logic clr, input logic rst);
    int n;
    logic [1:0] cause;
    logic [W-1:0] t;
    n = mn[k];
    cause = 2'd0;
    if (rst) begin
      mn[k] = 0; mef[k] = 1'b0; mec[k] = 2'd0;
      return;
    end
    case (o)
      3'd1: if (n == mcap[k]) cause = 2'd1; else begin ms[k][n] = d; mn[k] = n + 1; end
      3'd2: if (n == 0) cause = 2'd2; else mn[k] = n - 1;
      3'd3: if (n == 0) cause = 2'd2; else ms[k][n-1] = d;
      3'd4: if (n == 0) cause = 2'd2;
            else if (n == mcap[k]) cause = 2'd1;
            else begin ms[k][n] = ms[k][n-1]; mn[k] = n + 1; end
      3'd5: if (n < 2) cause = 2'd2;
            else begin t = ms[k][n-1]; ms[k][n-1] = ms[k][n-2]; ms[k][n-2] = t; end
      3'd6: mn[k] = 0;
      3'd7: cause = 2'd3;
      default: ;
    endcase
    if (cause != 2'd0) begin
      if (!mef[k] || clr) mec[k] = cause;
      mef[k] = 1'b1;
    end else if (clr) begin
      mef[k] = 1'b0;
      mec[k] = 2'd0;
    end
  endtask

  // Apply one cycle of stimulus to both DUTs and advance the models.
  task automatic drive(input logic [2:0] o, input logic [W-1:0] d, input logic clr, input logic rst);
    if4.op = o;  if4.data_in = d;  if4.err_clear = clr;
    if64.op = o; if64.data_in = d; if64.err_clear = clr;
    reset = rst;
    @(posedge clock);
    model_step(0, o, d, clr, rst);
    model_step(1, o, d, clr, rst);
    #1;
    reset = 1'b0;
    if4.op = OP_NOP;  if4.err_clear = 1'b0;
    if64.op = OP_NOP; if64.err_clear = 1'b0;
  endtask

  task automatic test_reset();
    drive(OP_NOP, '0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs_depth[k] !== 0 || obs_top[k] !== '0 || obs_next[k] !== '0 || obs_empty[k] !== 1'b1 ||
          obs_full[k] !== 1'b0 || obs_eflag[k] !== 1'b0 || obs_ecode[k] !== 2'd0) begin
        bad++;
        $display("FAIL reset[%0d]: got depth=%0d top=%h next=%h empty=%b full=%b ef=%b ec=%0d, want 0/0/0/1/0/0/0",
                 k, obs_depth[k], obs_top[k], obs_next[k], obs_empty[k], obs_full[k], obs_eflag[k], obs_ecode[k]);
      end
    end
  endtask

  task automatic test_push_pop();
    drive(OP_PUSH, 18'h00011, 1'b0, 1'b0);
    drive(OP_PUSH, 18'h00022, 1'b0, 1'b0);
    drive(OP_PUSH, 18'h00033, 1'b0, 1'b0);
    total++;
    if (obs_top[1] !== 18'h00033 || obs_next[1] !== 18'h00022 || obs_depth[1] !== 3) begin
      bad++;
      $display("FAIL push3: got top=%h next=%h depth=%0d, want 00033 00022 3", obs_top[1], obs_next[1], obs_depth[1]);
    end
    drive(OP_POP, '0, 1'b0, 1'b0);
    drive(OP_POP, '0, 1'b0, 1'b0);
    total++;
    if (obs_top[1] !== 18'h00011 || obs_next[1] !== '0 || obs_depth[1] !== 1 || obs_empty[1] !== 1'b0) begin
      bad++;
      $display("FAIL pop2: got top=%h next=%h depth=%0d empty=%b, want 00011 0 1 0",
               obs_top[1], obs_next[1], obs_depth[1], obs_empty[1]);
    end
  endtask

  task automatic test_overflow();
    drive(OP_CLEAR, '0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) drive(OP_PUSH, W'(i), 1'b0, 1'b0);
    total++;
    if (obs_full[0] !== 1'b1 || obs_depth[0] !== 4) begin
      bad++;
      $display("FAIL full4: got full=%b depth=%0d, want 1 4", obs_full[0], obs_depth[0]);
    end
    drive(OP_PUSH, 18'd5, 1'b0, 1'b0);
    total++;
    if (obs_top[0] !== 18'd4 || obs_next[0] !== 18'd3 || obs_full[0] !== 1'b1 ||
        obs_eflag[0] !== 1'b1 || obs_ecode[0] !== 2'd1) begin
      bad++;
      $display("FAIL ovf: got top=%h next=%h full=%b ef=%b ec=%0d, want 4 3 1 1 1",
               obs_top[0], obs_next[0], obs_full[0], obs_eflag[0], obs_ecode[0]);
    end
    total++;
    if (obs_eflag[1] !== 1'b0 || obs_depth[1] !== 5) begin
      bad++;
      $display("FAIL ovf64: got ef=%b depth=%0d, want 0 5", obs_eflag[1], obs_depth[1]);
    end
    drive(OP_POP, '0, 1'b0, 1'b0);
    total++;
    if (obs_top[0] !== 18'd3 || obs_eflag[0] !== 1'b1 || obs_ecode[0] !== 2'd1) begin
      bad++;
      $display("FAIL ovf_pop: got top=%h ef=%b ec=%0d, want 3 1 1", obs_top[0], obs_eflag[0], obs_ecode[0]);
    end
    drive(OP_NOP, '0, 1'b1, 1'b0);
    total++;
    if (obs_eflag[0] !== 1'b0 || obs_ecode[0] !== 2'd0) begin
      bad++;
      $display("FAIL err_clear: got ef=%b ec=%0d, want 0 0", obs_eflag[0], obs_ecode[0]);
    end
  endtask

  task automatic test_underflow();
    drive(OP_CLEAR, '0, 1'b1, 1'b0);
    drive(OP_POP, '0, 1'b0, 1'b0);
    total++;
    if (obs_ecode[1] !== 2'd2 || obs_eflag[1] !== 1'b1 || obs_depth[1] !== 0) begin
      bad++;
      $display("FAIL unf: got ec=%0d ef=%b depth=%0d, want 2 1 0", obs_ecode[1], obs_eflag[1], obs_depth[1]);
    end
    drive(OP_ILLEGAL, '0, 1'b0, 1'b0);
    total++;
    if (obs_ecode[1] !== 2'd2) begin
      bad++;
      $display("FAIL first_cause: got ec=%0d, want 2", obs_ecode[1]);
    end
    drive(OP_ILLEGAL, '0, 1'b1, 1'b0);
    total++;
    if (obs_ecode[1] !== 2'd3 || obs_eflag[1] !== 1'b1) begin
      bad++;
      $display("FAIL clr_vs_err: got ec=%0d ef=%b, want 3 1", obs_ecode[1], obs_eflag[1]);
    end
  endtask

  task automatic test_swap_dup();
    drive(OP_CLEAR, '0, 1'b1, 1'b0);
    drive(OP_PUSH, 18'h0000A, 1'b0, 1'b0);
    drive(OP_PUSH, 18'h0000B, 1'b0, 1'b0);
    drive(OP_SWAP, '0, 1'b0, 1'b0);
    total++;
    if (obs_top[1] !== 18'h0000A || obs_next[1] !== 18'h0000B) begin
      bad++;
      $display("FAIL swap: got top=%h next=%h, want 0000a 0000b", obs_top[1], obs_next[1]);
    end
    drive(OP_DUP, '0, 1'b0, 1'b0);
    total++;
    if (obs_top[1] !== 18'h0000A || obs_next[1] !== 18'h0000A || obs_depth[1] !== 3) begin
      bad++;
      $display("FAIL dup: got top=%h next=%h depth=%0d, want 0000a 0000a 3", obs_top[1], obs_next[1], obs_depth[1]);
    end
    drive(OP_REPLACE, 18'h3FFFF, 1'b0, 1'b0);
    total++;
    if (obs_top[1] !== 18'h3FFFF || obs_depth[1] !== 3 || obs_eflag[1] !== 1'b0) begin
      bad++;
      $display("FAIL replace: got top=%h depth=%0d ef=%b, want 3ffff 3 0", obs_top[1], obs_depth[1], obs_eflag[1]);
    end
    // Drain so the spilled 0xB comes back through the array.
    drive(OP_POP, '0, 1'b0, 1'b0);
    drive(OP_POP, '0, 1'b0, 1'b0);
    total++;
    if (obs_top[1] !== 18'h0000B || obs_depth[1] !== 1) begin
      bad++;
      $display("FAIL swap_drain: got top=%h depth=%0d, want 0000b 1", obs_top[1], obs_depth[1]);
    end
  endtask

  task automatic test_lifo();
    logic [W-1:0] vals [6];
    drive(OP_CLEAR, '0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      vals[i] = W'($urandom);
      drive(OP_PUSH, vals[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(OP_POP, '0, 1'b0, 1'b0);
      total++;
      if (i < 5) begin
        if (obs_top[1] !== vals[4-i] || obs_next[1] !== ((i < 4) ? vals[3-i] : '0)) begin
          bad++;
          $display("FAIL lifo pop%0d: got top=%h next=%h, want top=%h", i, obs_top[1], obs_next[1], vals[4-i]);
        end
      end else if (obs_empty[1] !== 1'b1 || obs_top[1] !== '0 || obs_depth[1] !== 0) begin
        bad++;
        $display("FAIL lifo empty: got empty=%b top=%h depth=%0d, want 1 0 0", obs_empty[1], obs_top[1], obs_depth[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(OP_CLEAR, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(OP_PUSH, W'(i + 7), 1'b0, 1'b0);
    drive(OP_ILLEGAL, '0, 1'b0, 1'b0);
    total++;
    if (obs_depth[1] !== 5 || obs_eflag[1] !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: got depth=%0d ef=%b, want 5 1", obs_depth[1], obs_eflag[1]);
    end
    drive(OP_PUSH, 18'h12345, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs_depth[k] !== 0 || obs_top[k] !== '0 || obs_next[k] !== '0 || obs_empty[k] !== 1'b1 ||
          obs_full[k] !== 1'b0 || obs_eflag[k] !== 1'b0 || obs_ecode[k] !== 2'd0) begin
        bad++;
        $display("FAIL reset_mid[%0d]: got depth=%0d top=%h next=%h empty=%b full=%b ef=%b ec=%0d, want 0/0/0/1/0/0/0",
                 k, obs_depth[k], obs_top[k], obs_next[k], obs_empty[k], obs_full[k], obs_eflag[k], obs_ecode[k]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [2:0] o;
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 99));
      if      (r < 35) o = OP_PUSH;
      else if (r < 60) o = OP_POP;
      else if (r < 68) o = OP_REPLACE;
      else if (r < 78) o = OP_DUP;
      else if (r < 88) o = OP_SWAP;
      else if (r < 91) o = OP_CLEAR;
      else if (r < 94) o = OP_ILLEGAL;
      else             o = OP_NOP;
      drive(o, W'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 149) == 0));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs_top[k] !== exp_top(k) || obs_next[k] !== exp_next(k) || obs_depth[k] !== 32'(mn[k]) ||
            obs_empty[k] !== (mn[k] == 0) || obs_full[k] !== (mn[k] == mcap[k]) ||
            obs_eflag[k] !== mef[k] || obs_ecode[k] !== mec[k]) begin
          bad++;
          $display("FAIL random[%0d] c=%0d op=%0d: got top=%h next=%h depth=%0d ef=%b ec=%0d, want top=%h next=%h depth=%0d ef=%b ec=%0d",
                   k, c, o, obs_top[k], obs_next[k], obs_depth[k], obs_eflag[k], obs_ecode[k],
                   exp_top(k), exp_next(k), mn[k], mef[k], mec[k]);
        end
      end
    end
  endtask

  initial begin
    mcap[0] = 4;  mcap[1] = 64;
    mn[0] = 0;    mn[1] = 0;
    mef[0] = 1'b0; mef[1] = 1'b0;
    mec[0] = 2'd0; mec[1] = 2'd0;
    if4.op = OP_NOP;  if4.data_in = '0;  if4.err_clear = 1'b0;
    if64.op = OP_NOP; if64.data_in = '0; if64.err_clear = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_swap_dup();
    test_lifo();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
